// File: rtl/serializer_flex.sv
// Parallel-to-serial converter with ready/valid input, one-word pending buffer,
// output backpressure, per-word length and bit order, and a last-bit marker.
module serializer_flex #(
    parameter int DATA_W  = 16,
    parameter int MOD_W   = $clog2(DATA_W),
    parameter int MIN_LEN = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_lsb_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              ser_last_o,
    input  logic              ser_rdy_i,
    output logic              busy_o,
    output logic              drop_o,
    output logic              dbg_state
);

    localparam int CNT_W = MOD_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] act_data;
    logic [CNT_W-1:0]  act_len;
    logic              act_lsb;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] pnd_data;
    logic [CNT_W-1:0]  pnd_len;
    logic              pnd_lsb;
    logic              pnd_valid;

    logic              drop_q;

    logic [CNT_W-1:0]  in_len;
    logic              in_legal;
    logic              accept;
    logic              load_legal;
    logic              drop_now;
    logic [MOD_W-1:0]  bit_idx;
    logic              is_last;
    logic              handshake;
    logic              last_hs;
    logic              to_active;

    // A zero length field encodes a full-width word.
    assign in_len     = (data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, data_mod_i};
    assign in_legal   = (in_len >= CNT_W'(MIN_LEN));
    assign accept     = data_val_i & data_rdy_o;
    assign load_legal = accept & in_legal;
    assign drop_now   = accept & ~in_legal;

    assign bit_idx    = act_lsb ? cnt[MOD_W-1:0]
                                : (MOD_W'(DATA_W - 1) - cnt[MOD_W-1:0]);
    assign is_last    = (cnt == (act_len - CNT_W'(1)));
    assign handshake  = ser_data_val_o & ser_rdy_i;
    assign last_hs    = handshake & ser_last_o;
    // Input goes straight to active only when nothing is queued ahead of it.
    assign to_active  = (state == IDLE) | (last_hs & ~pnd_valid);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_legal) state_next = SHIFT;
            SHIFT:   if (last_hs && !pnd_valid && !load_legal) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ser_data_val_o = 1'b0;
        ser_data_o     = 1'b0;
        ser_last_o     = 1'b0;
        if (state == SHIFT && !srst_i) begin
            ser_data_val_o = 1'b1;
            ser_data_o     = act_data[bit_idx];
            ser_last_o     = is_last;
        end
    end

    assign data_rdy_o = ~pnd_valid & ~srst_i;
    assign busy_o     = ((state == SHIFT) | pnd_valid) & ~srst_i;
    assign drop_o     = drop_q & ~srst_i;
    assign dbg_state  = state;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            act_data  <= '0;
            act_len   <= '0;
            act_lsb   <= 1'b0;
            cnt       <= '0;
            pnd_data  <= '0;
            pnd_len   <= '0;
            pnd_lsb   <= 1'b0;
            pnd_valid <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= drop_now;

            if (last_hs && pnd_valid) begin
                act_data <= pnd_data;
                act_len  <= pnd_len;
                act_lsb  <= pnd_lsb;
                cnt      <= '0;
            end else if (load_legal && to_active) begin
                act_data <= data_i;
                act_len  <= in_len;
                act_lsb  <= data_lsb_i;
                cnt      <= '0;
            end else if (last_hs) begin
                cnt <= '0;
            end else if (handshake) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (load_legal && !to_active) begin
                pnd_data  <= data_i;
                pnd_len   <= in_len;
                pnd_lsb   <= data_lsb_i;
                pnd_valid <= 1'b1;
            end else if (last_hs && pnd_valid) begin
                pnd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serializer_flex.sv
// Directed bench for serializer_flex: vector table of single words plus
// back-to-back, backpressure and mid-word reset sequences.
module tb_serializer_flex;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_lsb_i;
    logic        data_val_i;
    logic        data_rdy_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        ser_last_o;
    logic        ser_rdy_i;
    logic        busy_o;
    logic        drop_o;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        lsb;
        logic [15:0] exp_seq;
        int          exp_len;
    } vec_t;

    vec_t vecs[10];

    serializer_flex #(.DATA_W(16), .MOD_W(4), .MIN_LEN(3)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_lsb_i     (data_lsb_i),
        .data_val_i     (data_val_i),
        .data_rdy_o     (data_rdy_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_last_o     (ser_last_o),
        .ser_rdy_i      (ser_rdy_i),
        .busy_o         (busy_o),
        .drop_o         (drop_o),
        .dbg_state      (dbg_state)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops one expected {bit,last} per handshake; held bits are compared every cycle.
    task automatic collect(input int n, input logic [31:0] stall, input int budget,
                           output int gaps, output int first);
        int got;
        int c;
        int cyc;
        bit started;
        got = 0; c = 0; cyc = 0; started = 0;
        gaps = 0; first = -1;
        while (got < n && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            if (ser_data_val_o) begin
                if (!started) begin
                    started = 1;
                    first   = cyc;
                end
                ser_rdy_i = (c < 32) ? !stall[c] : 1'b1;
                check("ser_bit", ser_data_o, exp_q[0][1]);
                check("ser_last", ser_last_o, exp_q[0][0]);
                if (ser_rdy_i) begin
                    void'(exp_q.pop_front());
                    got++;
                end
                c++;
            end else begin
                ser_rdy_i = 1'b1;
                if (started) gaps++;
            end
        end
        check("bits_delivered", got, n);
        ser_rdy_i = 1'b1;
        exp_q.delete();
    endtask

    task automatic run_word(input logic [15:0] d, input logic [3:0] m, input logic l,
                            input logic [15:0] seq, input int len, input logic [31:0] stall);
        int gaps;
        int first;
        @(negedge clk_i);
        data_i = d; data_mod_i = m; data_lsb_i = l; data_val_i = 1'b1;
        check("rdy_before_accept", data_rdy_o, 1);
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
        if (len == 0) begin
            @(negedge clk_i);
            check("drop_pulse", drop_o, 1);
            check("drop_no_val", ser_data_val_o, 0);
            check("drop_rdy", data_rdy_o, 1);
            @(negedge clk_i);
            check("drop_cleared", drop_o, 0);
            check("drop_no_val2", ser_data_val_o, 0);
            check("drop_busy", busy_o, 0);
        end else begin
            for (int k = 0; k < len; k++) exp_q.push_back({seq[15-k], (k == len - 1)});
            collect(len, stall, 200, gaps, first);
            check("first_bit_latency", first, 1);
            check("gaps", gaps, 0);
            @(negedge clk_i);
            check("idle_val", ser_data_val_o, 0);
            check("idle_last", ser_last_o, 0);
            check("idle_busy", busy_o, 0);
        end
    endtask

    logic [15:0] w_data[3];
    logic        w_lsb[3];
    int          guard;
    int          gaps4;
    int          first4;
    int          vcount;
    bit          saw_low;

    initial begin
        vecs[0] = '{16'hA5C3, 4'd0,  1'b0, 16'hA5C3, 16};
        vecs[1] = '{16'h00F0, 4'd5,  1'b1, 16'h0800, 5};
        vecs[2] = '{16'hFFFF, 4'd1,  1'b0, 16'h0000, 0};
        vecs[3] = '{16'hFFFF, 4'd2,  1'b0, 16'h0000, 0};
        vecs[4] = '{16'hB000, 4'd3,  1'b0, 16'hA000, 3};
        vecs[5] = '{16'h0001, 4'd0,  1'b1, 16'h8000, 16};
        vecs[6] = '{16'h8000, 4'd8,  1'b0, 16'h8000, 8};
        vecs[7] = '{16'h00C5, 4'd8,  1'b1, 16'hA300, 8};
        vecs[8] = '{16'h0006, 4'd3,  1'b1, 16'h6000, 3};
        vecs[9] = '{16'hFFFE, 4'd15, 1'b0, 16'hFFFE, 15};

        srst_i = 1'b1; ser_rdy_i = 1'b1; data_val_i = 1'b0;
        data_i = '0; data_mod_i = '0; data_lsb_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_rdy", data_rdy_o, 0);
        check("reset_val", ser_data_val_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_drop", drop_o, 0);
        srst_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_rdy", data_rdy_o, 1);
        check("post_reset_val", ser_data_val_o, 0);
        check("post_reset_busy", busy_o, 0);

        for (int i = 0; i < 10; i++)
            run_word(vecs[i].data, vecs[i].mod, vecs[i].lsb, vecs[i].exp_seq, vecs[i].exp_len, 32'h0);

        // Backpressure mid-word and on the last bit.
        run_word(16'hC35A, 4'd0, 1'b0, 16'hC35A, 16, 32'h001C_00E0);

        // Three 4-bit words with data_val_i held: expect 12 gap-free bits.
        w_data[0] = 16'hA000; w_lsb[0] = 1'b0;
        w_data[1] = 16'h5000; w_lsb[1] = 1'b0;
        w_data[2] = 16'h0009; w_lsb[2] = 1'b1;
        exp_q.push_back(2'b10); exp_q.push_back(2'b00); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
        exp_q.push_back(2'b00); exp_q.push_back(2'b10); exp_q.push_back(2'b00); exp_q.push_back(2'b11);
        exp_q.push_back(2'b10); exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b11);
        saw_low = 0;
        @(negedge clk_i);
        fork
            begin
                for (int w = 0; w < 3; w++) begin
                    data_i = w_data[w]; data_mod_i = 4'd4; data_lsb_i = w_lsb[w]; data_val_i = 1'b1;
                    guard = 0;
                    while (!data_rdy_o && guard < 50) begin
                        saw_low = 1;
                        @(negedge clk_i);
                        guard++;
                    end
                    @(negedge clk_i);
                end
                data_val_i = 1'b0;
            end
            begin
                collect(12, 32'h0, 100, gaps4, first4);
            end
        join
        check("b2b_gaps", gaps4, 0);
        check("b2b_first", first4, 1);
        check("b2b_rdy_low_seen", saw_low, 1);
        @(negedge clk_i);
        check("b2b_idle_val", ser_data_val_o, 0);
        check("b2b_idle_busy", busy_o, 0);

        // Reset at bit 7 of a 16-bit word with a second word pending.
        @(negedge clk_i);
        data_i = 16'hFFFF; data_mod_i = 4'd0; data_lsb_i = 1'b0; data_val_i = 1'b1;
        @(posedge clk_i);
        #1 data_i = 16'h0F0F; data_mod_i = 4'd8;
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
        @(negedge clk_i);
        check("pend_full_rdy", data_rdy_o, 0);
        check("pend_full_busy", busy_o, 1);
        repeat (6) @(negedge clk_i);
        check("bit7_val", ser_data_val_o, 1);
        check("bit7_data", ser_data_o, 1);
        check("bit7_last", ser_last_o, 0);
        srst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_val", ser_data_val_o, 0);
        check("rst_mid_data", ser_data_o, 0);
        check("rst_mid_last", ser_last_o, 0);
        check("rst_mid_rdy", data_rdy_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_drop", drop_o, 0);
        srst_i = 1'b0;
        @(negedge clk_i);
        check("after_rst_rdy", data_rdy_o, 1);
        check("after_rst_busy", busy_o, 0);
        vcount = 0;
        repeat (20) begin
            if (ser_data_val_o) vcount++;
            @(negedge clk_i);
        end
        check("after_rst_no_bits", vcount, 0);
        run_word(16'h8001, 4'd0, 1'b0, 16'h8001, 16, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
